// File: rtl/float_divide.sv
// Sequential binary32 divider: OUT = IN1 / IN2, one quotient bit per cycle,
// round-to-nearest-even, denormals flushed to zero, div-by-zero/invalid flags.
module float_divide (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] IN1,
    input  logic [31:0] IN2,
    output logic [31:0] OUT,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic        invalid
);

    localparam int unsigned W   = 32;
    localparam int unsigned MW  = 24;
    localparam int unsigned QW  = 26;
    localparam int unsigned RW  = 25;
    localparam int unsigned EW  = 10;
    localparam int unsigned CW  = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_UNPACK,
        S_DIV,
        S_ROUND
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [W-1:0]         r_a_in;
    logic [W-1:0]         r_b_in;
    logic                 r_sign;
    logic signed [EW-1:0] r_exp;
    logic [MW-1:0]        r_divisor;
    logic [RW-1:0]        r_rem;
    logic [QW-1:0]        r_quo;
    logic [CW-1:0]        r_cnt;
    logic                 r_bypass;
    logic [W-1:0]         r_byp_out;
    logic                 r_byp_dbz;
    logic                 r_byp_inv;

    // Operand classification of the latched inputs
    logic [7:0]           w_e1;
    logic [7:0]           w_e2;
    logic [22:0]          w_m1;
    logic [22:0]          w_m2;
    logic                 w_sign;
    logic                 w_zero1;
    logic                 w_zero2;
    logic                 w_inf1;
    logic                 w_inf2;
    logic                 w_nan1;
    logic                 w_nan2;
    logic                 w_special;
    logic signed [EW-1:0] w_exp_diff;

    assign w_e1       = r_a_in[30:23];
    assign w_e2       = r_b_in[30:23];
    assign w_m1       = r_a_in[22:0];
    assign w_m2       = r_b_in[22:0];
    assign w_sign     = r_a_in[31] ^ r_b_in[31];
    assign w_zero1    = (w_e1 == 8'd0);
    assign w_zero2    = (w_e2 == 8'd0);
    assign w_inf1     = (w_e1 == 8'hFF) && (w_m1 == 23'd0);
    assign w_inf2     = (w_e2 == 8'hFF) && (w_m2 == 23'd0);
    assign w_nan1     = (w_e1 == 8'hFF) && (w_m1 != 23'd0);
    assign w_nan2     = (w_e2 == 8'hFF) && (w_m2 != 23'd0);
    assign w_special  = w_zero1 | w_zero2 | w_inf1 | w_inf2 | w_nan1 | w_nan2;
    assign w_exp_diff = $signed({2'b00, w_e1}) - $signed({2'b00, w_e2});

    logic [W-1:0]         w_byp_out;
    logic                 w_byp_dbz;
    logic                 w_byp_inv;

    // Special-operand result, checked in priority order
    always_comb begin
        w_byp_out = {w_sign, 31'd0};
        w_byp_dbz = 1'b0;
        w_byp_inv = 1'b0;
        if (w_nan1 | w_nan2 | (w_zero1 & w_zero2) | (w_inf1 & w_inf2)) begin
            w_byp_out = 32'h7FC0_0000;
            w_byp_inv = 1'b1;
        end else if (w_zero2 & ~w_inf1) begin
            w_byp_out = {w_sign, 8'hFF, 23'd0};
            w_byp_dbz = 1'b1;
        end else if (w_inf1) begin
            w_byp_out = {w_sign, 8'hFF, 23'd0};
        end
    end

    // Restoring division step: subtract divisor when it fits
    logic                 w_borrow;
    logic [RW-1:0]        w_trial;
    logic [RW-1:0]        w_rem_next;

    assign {w_borrow, w_trial} = {1'b0, r_rem} - {2'b00, r_divisor};
    assign w_rem_next          = w_borrow ? r_rem : w_trial;

    // Normalize and round the quotient
    logic                 w_hi;
    logic [22:0]          w_mant;
    logic                 w_guard;
    logic                 w_sticky;
    logic                 w_inc;
    logic [MW-1:0]        w_mant_sum;
    logic signed [EW-1:0] w_e_pre;
    logic signed [EW-1:0] w_e_rnd;
    logic [W-1:0]         w_round_out;

    assign w_hi       = r_quo[25];
    assign w_mant     = w_hi ? r_quo[24:2] : r_quo[23:1];
    assign w_guard    = w_hi ? r_quo[1] : r_quo[0];
    assign w_sticky   = (w_hi & r_quo[0]) | (r_rem != '0);
    assign w_inc      = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_sum = {1'b0, w_mant} + MW'(w_inc);
    assign w_e_pre    = r_exp + (w_hi ? 10'sd127 : 10'sd126);
    assign w_e_rnd    = w_mant_sum[23] ? (w_e_pre + 10'sd1) : w_e_pre;

    always_comb begin
        w_round_out = {r_sign, w_e_rnd[7:0], w_mant_sum[22:0]};
        if (w_e_rnd >= 10'sd255) begin
            w_round_out = {r_sign, 8'hFF, 23'd0};
        end else if (w_e_rnd <= 10'sd0) begin
            w_round_out = {r_sign, 31'd0};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_UNPACK;
            S_UNPACK: w_state_next = w_special ? S_ROUND : S_DIV;
            S_DIV:    if (r_cnt == '0) w_state_next = S_ROUND;
            S_ROUND:  w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_in      <= '0;
            r_b_in      <= '0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_bypass    <= 1'b0;
            r_byp_out   <= '0;
            r_byp_dbz   <= 1'b0;
            r_byp_inv   <= 1'b0;
            OUT         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_in <= IN1;
                        r_b_in <= IN2;
                        busy   <= 1'b1;
                    end
                end
                S_UNPACK: begin
                    r_sign    <= w_sign;
                    r_exp     <= w_exp_diff;
                    r_divisor <= {1'b1, w_m2};
                    r_rem     <= {2'b01, w_m1};
                    r_quo     <= '0;
                    r_cnt     <= CW'(QW - 1);
                    r_bypass  <= w_special;
                    r_byp_out <= w_byp_out;
                    r_byp_dbz <= w_byp_dbz;
                    r_byp_inv <= w_byp_inv;
                end
                S_DIV: begin
                    r_rem <= w_rem_next << 1;
                    r_quo <= {r_quo[QW-2:0], ~w_borrow};
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_ROUND: begin
                    OUT         <= r_bypass ? r_byp_out : w_round_out;
                    div_by_zero <= r_bypass & r_byp_dbz;
                    invalid     <= r_bypass & r_byp_inv;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_divide.sv
// Directed bench for float_divide: stimulus pushes expected results, a monitor
// pops and compares them whenever done is presented.
module tb_float_divide;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] IN1;
    logic [31:0] IN2;
    logic [31:0] OUT;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        invalid;

    float_divide dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .IN1         (IN1),
        .IN2         (IN2),
        .OUT         (OUT),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] out;
        logic        dbz;
        logic        inv;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d, OUT=%h)", cyc, OUT);
                end else begin
                    m_e = sb.pop_front();
                    check("out", OUT, m_e.out);
                    check("div_by_zero", 32'(div_by_zero), 32'(m_e.dbz));
                    check("invalid", 32'(invalid), 32'(m_e.inv));
                    check("done_cycle", 32'(cyc), 32'(m_e.at));
                end
            end
        end
    end

    task automatic push(input logic [31:0] out, input logic dbz, input logic inv, input int at);
        exp_t e;
        e.out = out;
        e.dbz = dbz;
        e.inv = inv;
        e.at  = at;
        sb.push_back(e);
    endtask

    // Drive one start; returns with the accepting edge passed, start still high if keep
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit keep, output int c0);
        @(negedge clk);
        IN1   = a;
        IN2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        if (!keep) start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] out,
                          input logic dbz, input logic inv, input int lat);
        int c0;
        issue(a, b, 1'b0, c0);
        push(out, dbz, inv, c0 + lat);
        wait_done("op", lat + 10);
    endtask

    initial begin
        int c0;
        int bad;
        reset = 1'b0;
        start = 1'b0;
        IN1   = '0;
        IN2   = '0;
        repeat (3) @(negedge clk);
        check("rst_out", OUT, 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_dbz", 32'(div_by_zero), 32'h0);
        check("rst_inv", 32'(invalid), 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // 6/2 with busy tracking across the whole operation
        issue(32'h40C0_0000, 32'h4000_0000, 1'b0, c0);
        push(32'h4040_0000, 1'b0, 1'b0, c0 + 28);
        check("busy_edge0", 32'(busy), 32'h1);
        bad = 0;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            if (busy !== 1'b1) bad++;
        end
        check("busy_hold_cycles_low", 32'(bad), 32'h0);
        wait_done("six_by_two", 10);
        check("busy_at_done", 32'(busy), 32'h0);

        run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0, 28);
        run_op(32'hBF80_0000, 32'h4040_0000, 32'hBEAA_AAAB, 1'b0, 1'b0, 28);

        // Special operands
        run_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1'b0, 2);
        run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b1, 2);
        run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0, 2);
        run_op(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b1, 2);
        run_op(32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b0, 2);
        run_op(32'h4000_0000, 32'hFF80_0000, 32'h8000_0000, 1'b0, 1'b0, 2);
        run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b1, 2);

        // Range limits after rounding
        run_op(32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 1'b0, 1'b0, 28);
        run_op(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 28);

        // Starts while busy are ignored
        issue(32'h40C0_0000, 32'h4000_0000, 1'b0, c0);
        push(32'h4040_0000, 1'b0, 1'b0, c0 + 28);
        wait_until(c0 + 5);
        IN1 = 32'h3F80_0000; IN2 = 32'h4040_0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_until(c0 + 10);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ignore", 30);
        repeat (35) @(negedge clk);

        // Start held through done: second op accepted in the done cycle
        issue(32'h40C0_0000, 32'h4000_0000, 1'b1, c0);
        push(32'h4040_0000, 1'b0, 1'b0, c0 + 28);
        push(32'h3EAA_AAAB, 1'b0, 1'b0, c0 + 57);
        IN1 = 32'h3F80_0000;
        IN2 = 32'h4040_0000;
        wait_done("b2b_first", 40);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("b2b_second", 40);

        // Reset mid-operation discards the result
        issue(32'h40C0_0000, 32'h4000_0000, 1'b0, c0);
        wait_until(c0 + 12);
        reset = 1'b0;
        #1;
        check("midrst_out", OUT, 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 28);

        repeat (5) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_results: got %0d outstanding expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
